datapath_unit: RTL and testbench

DATAPATH_UNIT -- requirements
Module: datapath_unit

---
 rtl/datapath_unit_pkg.sv | 21 ++
 rtl/datapath_unit_register_file.sv | 36 +++
 rtl/datapath_unit.sv | 87 ++++++++
 tb/tb_datapath_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_unit_pkg.sv
// Shared definitions for the control FSM and the datapath: ALU function codes.
package StateDefs;

  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ZERO   = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_PASS_A = 3'd3,
    ALU_PASS_B = 3'd4,
    ALU_XOR    = 3'd5,
    ALU_OR     = 3'd6,
    ALU_AND    = 3'd7
  } alu_op;

  function automatic alu_op to_alu_op(input logic [ALU_OP_W-1:0] code);
    return alu_op'(code);
  endfunction

endpackage

// File: rtl/datapath_unit_register_file.sv
// Register file: two combinational read ports, one synchronous write port,
// all entries cleared by the synchronous active-low reset.
module register_file #(
  parameter int DATA_W   = 16,
  parameter int RF_DEPTH = 16,
  localparam int AW      = $clog2(RF_DEPTH)
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_ra_addr,
  input  logic [AW-1:0]     i_rb_addr,
  output logic [DATA_W-1:0] o_ra_data,
  output logic [DATA_W-1:0] o_rb_data
);

  logic [DATA_W-1:0] r_regs [RF_DEPTH];

  // Reset clears every entry and blocks any write requested in the same cycle
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // No write bypass: a same-cycle write shows up only after the edge
  assign o_ra_data = r_regs[i_ra_addr];
  assign o_rb_data = r_regs[i_rb_addr];

endmodule

// File: rtl/datapath_unit.sv
// Datapath: register file, 8-function ALU, write-back mux and a single-port
// data RAM with registered, read-first output.
module datapath_unit
  import StateDefs::*;
#(
  parameter int DATA_W     = 16,
  parameter int RF_DEPTH   = 16,
  parameter int DMEM_DEPTH = 256
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              D_wr,
  input  logic [7:0]        D_addr,
  input  logic              RF_s,
  input  logic              RF_W_en,
  input  logic [3:0]        RF_W_addr,
  input  logic [3:0]        RF_Ra_addr,
  input  logic [3:0]        RF_Rb_addr,
  input  logic [2:0]        Alu_s0,
  output logic [DATA_W-1:0] Ra_data,
  output logic [DATA_W-1:0] Rb_data,
  output logic [DATA_W-1:0] ALU_out,
  output logic              ALU_zero,
  output logic [DATA_W-1:0] Mem_rdata
);

  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  logic [DATA_W-1:0]  r_dmem [DMEM_DEPTH];
  logic [DATA_W-1:0]  w_wb_data;
  logic [DMEM_AW-1:0] w_dmem_idx;
  alu_op              w_alu_op;

  assign w_dmem_idx = D_addr[DMEM_AW-1:0];
  assign w_alu_op   = to_alu_op(Alu_s0);

  register_file #(
    .DATA_W   (DATA_W),
    .RF_DEPTH (RF_DEPTH)
  ) u_register_file (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .i_we      (RF_W_en),
    .i_waddr   (RF_W_addr),
    .i_wdata   (w_wb_data),
    .i_ra_addr (RF_Ra_addr),
    .i_rb_addr (RF_Rb_addr),
    .o_ra_data (Ra_data),
    .o_rb_data (Rb_data)
  );

  // ALU; add/sub wrap naturally at DATA_W bits
  always_comb begin
    ALU_out = '0;
    case (w_alu_op)
      ALU_ZERO:   ALU_out = '0;
      ALU_ADD:    ALU_out = Ra_data + Rb_data;
      ALU_SUB:    ALU_out = Ra_data - Rb_data;
      ALU_PASS_A: ALU_out = Ra_data;
      ALU_PASS_B: ALU_out = Rb_data;
      ALU_XOR:    ALU_out = Ra_data ^ Rb_data;
      ALU_OR:     ALU_out = Ra_data | Rb_data;
      ALU_AND:    ALU_out = Ra_data & Rb_data;
      default:    ALU_out = '0;
    endcase
  end

  assign ALU_zero  = (ALU_out == '0);
  assign w_wb_data = RF_s ? Mem_rdata : ALU_out;

  // RAM contents survive reset; only the write is gated so it stays inferable
  always_ff @(posedge Clk) begin
    if (ResetN && D_wr) begin
      r_dmem[w_dmem_idx] <= Ra_data;
    end
  end

  // Registered read samples the pre-write word (read-first)
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      Mem_rdata <= '0;
    end else begin
      Mem_rdata <= r_dmem[w_dmem_idx];
    end
  end

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: directed scenarios then random traffic,
// all compared against an array-based behavioural model.
module tb_datapath_unit;

  logic        Clk = 1'b0;
  logic        ResetN;
  logic        D_wr;
  logic [7:0]  D_addr;
  logic        RF_s;
  logic        RF_W_en;
  logic [3:0]  RF_W_addr;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  Alu_s0;
  logic [15:0] Ra_data;
  logic [15:0] Rb_data;
  logic [15:0] ALU_out;
  logic        ALU_zero;
  logic [15:0] Mem_rdata;

  datapath_unit dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .D_wr       (D_wr),
    .D_addr     (D_addr),
    .RF_s       (RF_s),
    .RF_W_en    (RF_W_en),
    .RF_W_addr  (RF_W_addr),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .Alu_s0     (Alu_s0),
    .Ra_data    (Ra_data),
    .Rb_data    (Rb_data),
    .ALU_out    (ALU_out),
    .ALU_zero   (ALU_zero),
    .Mem_rdata  (Mem_rdata)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  logic [15:0] rf_m [16];
  logic [15:0] mem_m [256];
  bit          mem_known [256];
  logic [15:0] rdata_m;
  bit          rdata_known;
  bit          wb_ovr;
  logic [15:0] wb_ovr_val;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] alu_ref(input int op, input int a, input int b);
    int r;
    case (op)
      0:       r = 0;
      1:       r = (a + b) % 65536;
      2:       r = (a - b + 65536) % 65536;
      3:       r = a;
      4:       r = b;
      5:       r = a ^ b;
      6:       r = a | b;
      7:       r = a & b;
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [15:0] a, b, y;
    a = rf_m[RF_Ra_addr];
    b = rf_m[RF_Rb_addr];
    y = alu_ref(int'(Alu_s0), int'(a), int'(b));
    chk({tag, "_ra"}, Ra_data, a);
    chk({tag, "_rb"}, Rb_data, b);
    chk({tag, "_alu"}, ALU_out, y);
    chk({tag, "_zero"}, {15'd0, ALU_zero}, {15'd0, (y == 16'h0000)});
    if (rdata_known) chk({tag, "_rdata"}, Mem_rdata, rdata_m);
  endtask

  // One clock edge: the model uses the values present before the edge
  task automatic cycle();
    logic [15:0] a, wb, nrd;
    bit nk;
    a  = rf_m[RF_Ra_addr];
    wb = wb_ovr ? wb_ovr_val
         : (RF_s ? rdata_m : alu_ref(int'(Alu_s0), int'(a), int'(rf_m[RF_Rb_addr])));
    @(posedge Clk);
    #1;
    if (!ResetN) begin
      for (int i = 0; i < 16; i++) rf_m[i] = 16'h0000;
      rdata_m = 16'h0000;
      rdata_known = 1'b1;
    end else begin
      nrd = mem_m[D_addr];
      nk  = mem_known[D_addr];
      if (D_wr) begin
        mem_m[D_addr] = a;
        mem_known[D_addr] = 1'b1;
      end
      if (RF_W_en) rf_m[RF_W_addr] = wb;
      rdata_m = nrd;
      rdata_known = nk;
    end
  endtask

  // Place an arbitrary value in a register by overriding the write-back path
  task automatic poke(input logic [3:0] addr, input logic [15:0] val);
    RF_W_en = 1'b1;
    RF_W_addr = addr;
    wb_ovr = 1'b1;
    wb_ovr_val = val;
    force dut.w_wb_data = wb_ovr_val;
    cycle();
    release dut.w_wb_data;
    wb_ovr = 1'b0;
    RF_W_en = 1'b0;
  endtask

  initial begin
    ResetN = 1'b0; D_wr = 1'b0; D_addr = 8'h00; RF_s = 1'b0; RF_W_en = 1'b0;
    RF_W_addr = 4'h0; RF_Ra_addr = 4'h0; RF_Rb_addr = 4'h0; Alu_s0 = 3'd0;
    wb_ovr = 1'b0; wb_ovr_val = 16'h0000;
    for (int i = 0; i < 16; i++) rf_m[i] = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = 16'h0000;
      mem_known[i] = 1'b0;
    end
    rdata_m = 16'h0000;
    rdata_known = 1'b0;

    // Reset, then every RF address reads zero
    cycle();
    cycle();
    chk("rst_mem_rdata", Mem_rdata, 16'h0000);
    ResetN = 1'b1;
    Alu_s0 = 3'd1;
    for (int i = 0; i < 16; i++) begin
      RF_Ra_addr = 4'(i);
      RF_Rb_addr = 4'(15 - i);
      #1;
      chk("rst_ra", Ra_data, 16'h0000);
      chk("rst_rb", Rb_data, 16'h0000);
      chk("rst_alu", ALU_out, 16'h0000);
    end

    // Store R2 to mem[0x10], then two-cycle load into R5
    poke(4'd2, 16'h1234);
    RF_Ra_addr = 4'd2; D_addr = 8'h10; D_wr = 1'b1;
    cycle();
    D_wr = 1'b0;
    check_outputs("store");
    RF_Ra_addr = 4'd5;
    cycle();
    chk("load_r5_first", Ra_data, 16'h0000);
    chk("load_rdata", Mem_rdata, 16'h1234);
    RF_W_en = 1'b1; RF_s = 1'b1; RF_W_addr = 4'd5;
    cycle();
    RF_W_en = 1'b0; RF_s = 1'b0;
    chk("load_r5", Ra_data, 16'h1234);
    check_outputs("load");

    // Add and subtract
    poke(4'd1, 16'h0005);
    poke(4'd2, 16'h0003);
    RF_Ra_addr = 4'd1; RF_Rb_addr = 4'd2; Alu_s0 = 3'd1;
    RF_W_en = 1'b1; RF_W_addr = 4'd3;
    cycle();
    Alu_s0 = 3'd2; RF_W_addr = 4'd4;
    cycle();
    RF_W_en = 1'b0;
    RF_Ra_addr = 4'd3; RF_Rb_addr = 4'd4;
    #1;
    chk("add_r3", Ra_data, 16'h0008);
    chk("sub_r4", Rb_data, 16'h0002);
    RF_Ra_addr = 4'd2; RF_Rb_addr = 4'd1; Alu_s0 = 3'd2;
    #1;
    chk("sub_wrap", ALU_out, 16'hFFFE);
    chk("sub_wrap_zero", {15'd0, ALU_zero}, 16'h0000);

    // Add wraps to zero
    poke(4'd1, 16'hFFFF);
    poke(4'd6, 16'h0001);
    RF_Ra_addr = 4'd1; RF_Rb_addr = 4'd6; Alu_s0 = 3'd1;
    #1;
    chk("add_wrap", ALU_out, 16'h0000);
    chk("add_wrap_zero", {15'd0, ALU_zero}, 16'h0001);

    // Same-cycle write and read of R7: no bypass
    poke(4'd7, 16'hAAAA);
    RF_Ra_addr = 4'd7; RF_Rb_addr = 4'd1; Alu_s0 = 3'd1;
    RF_W_en = 1'b1; RF_W_addr = 4'd7;
    #1;
    chk("nobypass_old", Ra_data, 16'hAAAA);
    cycle();
    RF_W_en = 1'b0;
    chk("nobypass_new", Ra_data, 16'hAAA9);

    // Read-first on same-address write
    D_addr = 8'h10; D_wr = 1'b1;
    cycle();
    D_wr = 1'b0;
    chk("read_first_old", Mem_rdata, 16'h1234);
    cycle();
    chk("read_first_new", Mem_rdata, 16'hAAA9);

    // Hold with all enables low
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_outputs("hold");
    end
    chk("hold_r7", Ra_data, 16'hAAA9);

    // Reset with writes requested: suppressed, memory preserved
    ResetN = 1'b0; RF_W_en = 1'b1; RF_W_addr = 4'd7; D_wr = 1'b1; D_addr = 8'h10;
    RF_Ra_addr = 4'd1;
    cycle();
    cycle();
    ResetN = 1'b1; RF_W_en = 1'b0; D_wr = 1'b0;
    chk("rst2_rdata", Mem_rdata, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      RF_Ra_addr = 4'(i);
      #1;
      chk("rst2_ra", Ra_data, 16'h0000);
    end
    cycle();
    chk("rst2_mem_kept", Mem_rdata, 16'hAAA9);

    // Seed registers with random values, then random traffic
    for (int i = 0; i < 16; i++) poke(4'(i), 16'($urandom));
    for (int n = 0; n < 300; n++) begin
      ResetN     = ($urandom_range(0, 31) != 0);
      D_wr       = 1'($urandom_range(0, 1));
      D_addr     = 8'(16 + $urandom_range(0, 7));
      RF_s       = rdata_known ? 1'($urandom_range(0, 1)) : 1'b0;
      RF_W_en    = 1'($urandom_range(0, 1));
      RF_W_addr  = 4'($urandom);
      RF_Ra_addr = 4'($urandom);
      RF_Rb_addr = 4'($urandom);
      Alu_s0     = 3'($urandom);
      #1;
      check_outputs("rand_pre");
      cycle();
      check_outputs("rand_post");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
